// File: rtl/aes_pkg.sv
// Shared AES block geometry, PKCS#7 constants and the packer FSM encoding.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W  = 128;
  localparam int unsigned AES_BYTES    = 16;
  localparam logic [7:0]  AES_PAD_FULL = 8'h10;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    FLUSH  = 2'd1,
    PADBLK = 2'd2
  } pk_state_e;

  // PKCS#7 fill value for a block holding n message bytes (n in 1..16).
  function automatic logic [7:0] pkcs7_pad_byte(input logic [4:0] n);
    logic [4:0] diff;
    diff = 5'd16 - n;
    return {3'b000, diff};
  endfunction

endpackage

// File: rtl/pkcs7_pad.sv
// Combinational finisher for a partial block: slots at and beyond n take the
// PKCS#7 pad byte when pad_en is set, otherwise zero.
module pkcs7_pad
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] acc,
  input  logic [4:0]             n,
  input  logic                   pad_en,
  output logic [AES_BLOCK_W-1:0] padded
);

  logic [7:0] pad_byte_s;

  // Fill value shared by every slot past the message data.
  always_comb begin
    if (pad_en) begin
      pad_byte_s = pkcs7_pad_byte(n);
    end else begin
      pad_byte_s = 8'h00;
    end
  end

  // Keep bytes 0..n-1, replace the rest; byte 0 sits in the top lane.
  always_comb begin
    padded = acc;
    for (int i = 0; i < AES_BYTES; i++) begin
      if (5'(i) >= n) begin
        padded[AES_BLOCK_W-1-8*i -: 8] = pad_byte_s;
      end else begin
        padded[AES_BLOCK_W-1-8*i -: 8] = acc[AES_BLOCK_W-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit plaintext blocks for the AES datapath,
// padding the last block of each message, behind a registered valid/ready port.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int PAD_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [AES_BLOCK_W-1:0] m_block,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [4:0]             m_nbytes
);

  localparam logic PAD_ON_C = 1'(PAD_EN != 0);

  pk_state_e              state_r, state_nxt_s;
  logic [AES_BLOCK_W-1:0] acc_r, acc_nxt_s, acc_ins_s, acc_pad_s;
  logic [3:0]             cnt_r, cnt_nxt_s;
  logic [4:0]             n_r, n_nxt_s, n_fill_s;
  logic                   last_f_r, last_f_nxt_s;
  logic                   accept_s, out_free_s;
  logic                   load_s, ld_last_s;
  logic [AES_BLOCK_W-1:0] ld_block_s;
  logic [4:0]             ld_nbytes_s;

  assign s_ready    = (state_r == FILL) && !rst;
  assign accept_s   = s_valid && s_ready;
  assign out_free_s = !m_valid || m_ready;
  assign n_fill_s   = {1'b0, cnt_r} + 5'd1;

  // Drop the incoming byte into slot cnt of the accumulator.
  always_comb begin
    acc_ins_s = acc_r;
    for (int i = 0; i < AES_BYTES; i++) begin
      if (cnt_r == 4'(i)) begin
        acc_ins_s[AES_BLOCK_W-1-8*i -: 8] = s_data;
      end else begin
        acc_ins_s[AES_BLOCK_W-1-8*i -: 8] = acc_r[AES_BLOCK_W-1-8*i -: 8];
      end
    end
  end

  pkcs7_pad u_pad (
    .acc    (acc_ins_s),
    .n      (n_fill_s),
    .pad_en (PAD_ON_C),
    .padded (acc_pad_s)
  );

  // Next-state and output-register load decisions.
  always_comb begin
    state_nxt_s  = state_r;
    acc_nxt_s    = acc_r;
    cnt_nxt_s    = cnt_r;
    n_nxt_s      = n_r;
    last_f_nxt_s = last_f_r;
    load_s       = 1'b0;
    ld_block_s   = acc_r;
    ld_nbytes_s  = n_r;
    ld_last_s    = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          cnt_nxt_s = cnt_r + 4'd1;
          if ((cnt_r == 4'd15) || s_last) begin
            acc_nxt_s    = acc_pad_s;
            n_nxt_s      = n_fill_s;
            last_f_nxt_s = s_last;
            state_nxt_s  = FLUSH;
          end else begin
            acc_nxt_s = acc_ins_s;
          end
        end else begin
          acc_nxt_s = acc_r;
        end
      end
      FLUSH: begin
        if (out_free_s) begin
          load_s      = 1'b1;
          ld_block_s  = acc_r;
          ld_nbytes_s = n_r;
          ld_last_s   = last_f_r && !(PAD_ON_C && (n_r == 5'd16));
          // A full final block still owes the standalone pad block.
          if (last_f_r && PAD_ON_C && (n_r == 5'd16)) begin
            state_nxt_s = PADBLK;
          end else begin
            state_nxt_s = FILL;
            cnt_nxt_s   = 4'd0;
            acc_nxt_s   = '0;
          end
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      PADBLK: begin
        if (out_free_s) begin
          load_s      = 1'b1;
          ld_block_s  = {AES_BYTES{AES_PAD_FULL}};
          ld_nbytes_s = 5'd0;
          ld_last_s   = 1'b1;
          state_nxt_s = FILL;
          cnt_nxt_s   = 4'd0;
          acc_nxt_s   = '0;
        end else begin
          state_nxt_s = PADBLK;
        end
      end
      default: begin
        state_nxt_s = FILL;
        cnt_nxt_s   = 4'd0;
        acc_nxt_s   = '0;
      end
    endcase
  end

  // Packing state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= FILL;
      acc_r    <= '0;
      cnt_r    <= 4'd0;
      n_r      <= 5'd0;
      last_f_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      acc_r    <= acc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      n_r      <= n_nxt_s;
      last_f_r <= last_f_nxt_s;
    end
  end

  // Output register: holds until taken, reloads back-to-back when possible.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_block  <= '0;
      m_last   <= 1'b0;
      m_nbytes <= 5'd0;
    end else if (load_s) begin
      m_valid  <= 1'b1;
      m_block  <= ld_block_s;
      m_last   <= ld_last_s;
      m_nbytes <= ld_nbytes_s;
    end else if (m_ready) begin
      m_valid  <= 1'b0;
    end else begin
      m_valid  <= m_valid;
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: one padding instance, one zero-fill instance.
module tb_aes_block_packer;

  logic         clk;
  logic         rst;
  logic [7:0]   p_s_data,  z_s_data;
  logic         p_s_valid, z_s_valid;
  logic         p_s_last,  z_s_last;
  logic         p_s_ready, z_s_ready;
  logic [127:0] p_m_block, z_m_block;
  logic         p_m_valid, z_m_valid;
  logic         p_m_ready, z_m_ready;
  logic         p_m_last,  z_m_last;
  logic [4:0]   p_m_nbytes, z_m_nbytes;

  int tests = 0;
  int fails = 0;

  logic [127:0] qp_blk[$], qz_blk[$];
  logic [4:0]   qp_nb[$],  qz_nb[$];
  logic         qp_last[$], qz_last[$];

  aes_block_packer #(.PAD_EN(1)) dut_p (
    .clk(clk), .rst(rst), .s_data(p_s_data), .s_valid(p_s_valid), .s_last(p_s_last),
    .s_ready(p_s_ready), .m_block(p_m_block), .m_valid(p_m_valid), .m_ready(p_m_ready),
    .m_last(p_m_last), .m_nbytes(p_m_nbytes)
  );

  aes_block_packer #(.PAD_EN(0)) dut_z (
    .clk(clk), .rst(rst), .s_data(z_s_data), .s_valid(z_s_valid), .s_last(z_s_last),
    .s_ready(z_s_ready), .m_block(z_m_block), .m_valid(z_m_valid), .m_ready(z_m_ready),
    .m_last(z_m_last), .m_nbytes(z_m_nbytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (p_m_valid && p_m_ready) begin
      qp_blk.push_back(p_m_block);
      qp_nb.push_back(p_m_nbytes);
      qp_last.push_back(p_m_last);
    end
    if (z_m_valid && z_m_ready) begin
      qz_blk.push_back(z_m_block);
      qz_nb.push_back(z_m_nbytes);
      qz_last.push_back(z_m_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic l);
    int k;
    k = 0;
    @(negedge clk);
    if (sel) begin z_s_data = d; z_s_last = l; z_s_valid = 1'b1; end
    else     begin p_s_data = d; p_s_last = l; p_s_valid = 1'b1; end
    while (!(sel ? z_s_ready : p_s_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: got s_ready low expected high");
    end
    @(posedge clk);
    #1;
    if (sel) begin z_s_valid = 1'b0; z_s_last = 1'b0; end
    else     begin p_s_valid = 1'b0; p_s_last = 1'b0; end
  endtask

  task automatic expect_block(input bit sel, input string tag, input logic [127:0] eb,
                              input logic [4:0] en, input logic el);
    int k;
    logic [127:0] b;
    logic [4:0]   nb;
    logic         la;
    k = 0;
    while (((sel ? qz_blk.size() : qp_blk.size()) == 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if ((sel ? qz_blk.size() : qp_blk.size()) == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_timeout: got no block expected one", tag);
    end else begin
      if (sel) begin b = qz_blk.pop_front(); nb = qz_nb.pop_front(); la = qz_last.pop_front(); end
      else     begin b = qp_blk.pop_front(); nb = qp_nb.pop_front(); la = qp_last.pop_front(); end
      chk({tag, "_blk"}, b, eb);
      chk({tag, "_nb"}, 128'(nb), 128'(en));
      chk({tag, "_last"}, 128'(la), 128'(el));
    end
  endtask

  task automatic expect_none(input bit sel, input string tag);
    repeat (40) @(negedge clk);
    chk(tag, 128'(sel ? qz_blk.size() : qp_blk.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] fips;
    logic [127:0] held;
    rst = 1'b1;
    p_s_data = 8'h00; p_s_valid = 1'b0; p_s_last = 1'b0; p_m_ready = 1'b1;
    z_s_data = 8'h00; z_s_valid = 1'b0; z_s_last = 1'b0; z_m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sready", 128'(p_s_ready), 128'd0);
    chk("rst_mvalid", 128'(p_m_valid), 128'd0);
    chk("rst_mblock", p_m_block, 128'd0);
    chk("rst_mnbytes", 128'(p_m_nbytes), 128'd0);
    chk("rst_mlast", 128'(p_m_last), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Exact 16-byte message: data block then standalone pad block.
    for (int i = 0; i < 16; i++) send(1'b0, 8'(i), i == 15);
    @(negedge clk);
    chk("t1_flush_sready", 128'(p_s_ready), 128'd0);
    chk("t1_lat_pre", 128'(p_m_valid), 128'd0);
    @(negedge clk);
    chk("t1_lat", 128'(p_m_valid), 128'd1);
    expect_block(1'b0, "t1_b0", 128'h000102030405060708090a0b0c0d0e0f, 5'd16, 1'b0);
    expect_block(1'b0, "t1_pad", 128'h10101010101010101010101010101010, 5'd0, 1'b1);
    expect_none(1'b0, "t1_none");

    // Short message.
    send(1'b0, 8'hAA, 1'b0);
    send(1'b0, 8'hBB, 1'b0);
    send(1'b0, 8'hCC, 1'b1);
    expect_block(1'b0, "t2", 128'haabbcc_0d0d0d0d0d_0d0d0d0d0d_0d0d0d, 5'd3, 1'b1);
    expect_none(1'b0, "t2_none");

    // Last on the first byte.
    send(1'b0, 8'h7E, 1'b1);
    expect_block(1'b0, "t1byte", 128'h7e_0f0f0f0f0f_0f0f0f0f0f_0f0f0f0f0f, 5'd1, 1'b1);

    // 32 bytes with the consumer stalled after the first block appears.
    p_m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send(1'b0, 8'(i), i == 31);
      end
      begin
        int k;
        k = 0;
        while (!p_m_valid && k < 300) begin
          @(negedge clk);
          k++;
        end
        held = p_m_block;
        chk("t3_first_valid", 128'(p_m_valid), 128'd1);
        repeat (5) begin
          @(negedge clk);
          chk("t3_hold_valid", 128'(p_m_valid), 128'd1);
          chk("t3_hold_blk", p_m_block, held);
        end
        @(posedge clk);
        #1 p_m_ready = 1'b1;
      end
    join
    expect_block(1'b0, "t3_b0", 128'h000102030405060708090a0b0c0d0e0f, 5'd16, 1'b0);
    expect_block(1'b0, "t3_b1", 128'h101112131415161718191a1b1c1d1e1f, 5'd16, 1'b0);
    expect_block(1'b0, "t3_pad", 128'h10101010101010101010101010101010, 5'd0, 1'b1);
    expect_none(1'b0, "t3_none");

    // Reset mid-block discards the partial data.
    for (int i = 0; i < 7; i++) send(1'b0, 8'hE0 + 8'(i), 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_sready", 128'(p_s_ready), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_mvalid", 128'(p_m_valid), 128'd0);
    for (int i = 0; i < 16; i++) send(1'b0, 8'h55, i == 15);
    expect_block(1'b0, "t4_b0", 128'h55555555_55555555_55555555_55555555, 5'd16, 1'b0);
    expect_block(1'b0, "t4_pad", 128'h10101010101010101010101010101010, 5'd0, 1'b1);
    expect_none(1'b0, "t4_none");

    // Zero-fill instance: partial block, then an exact 16-byte message.
    for (int i = 1; i <= 5; i++) send(1'b1, 8'(i), i == 5);
    expect_block(1'b1, "t5", 128'h0102030405_0000000000_0000000000_00, 5'd5, 1'b1);
    expect_none(1'b1, "t5_none");
    fips = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < 16; i++) send(1'b1, fips[127-8*i -: 8], i == 15);
    expect_block(1'b1, "t6", 128'h00112233445566778899aabbccddeeff, 5'd16, 1'b1);
    expect_none(1'b1, "t6_none");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
